id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between the decode/register-file read stage and the execute stage of the 5-stage MIPS core.
- Captures the register-file operands, immediate, register specifiers and decoded control each cycle.
- Supports stall (hold) and flush (bubble insertion), and bypasses same-cycle writeback data into captured or held operands.
- Also produces the load-use hazard stall request for the front end.

Parameters:
- DW, 32, datapath width (operands, immediate, pc+4)
- AW, 5, register specifier width
- CW, 10, width of decoded control bundle {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[3:0]}

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- id_valid  in  1  decode stage holds a real instruction
- id_rs, id_rt, id_rd  in  AW each  register specifiers from decode
- id_rdata1, id_rdata2  in  DW each  register-file read data for rs/rt
- id_imm  in  DW  sign/zero-extended immediate
- id_pc4  in  DW  pc+4 of decoded instruction
- id_ctrl  in  CW  decoded control bundle
- stall  in  1  hold current contents (from hazard logic)
- flush  in  1  replace contents with a bubble (branch/jump redirect)
- wb_regwrite  in  1  writeback stage writes register file this cycle
- wb_reg  in  AW  writeback destination
- wb_data  in  DW  writeback data
- ex_valid  out  1  execute-stage instruction is real
- ex_rs, ex_rt, ex_rd  out  AW each
- ex_rdata1, ex_rdata2  out  DW each
- ex_imm, ex_pc4  out  DW each
- ex_ctrl  out  CW
- load_use_stall  out  1  combinational stall request to PC/IF-ID

Behaviour:
- Reset (reset==0, asynchronous): every registered output is 0; ex_valid=0, ex_ctrl=0. load_use_stall therefore reads 0.
- Update priority on each rising clk: flush > stall > load.
- Flush: ex_valid<=0, ex_ctrl<=0. Data fields are don't-care; the implementation clears them to 0.
- Stall (no flush): all fields hold, except the operand bypass below.
- Load (neither asserted): every ex_* field <= its id_* counterpart; ex_valid<=id_valid. If id_valid==0, ex_ctrl<=0.
- Bypass on load: if wb_regwrite && wb_reg!=0 && wb_reg==id_rs, ex_rdata1<=wb_data, else id_rdata1. Same rule for rt/rdata2. Both bypasses may fire on the same cycle.
- Bypass on stall: if ex_valid && wb_regwrite && wb_reg!=0 && wb_reg==ex_rs, ex_rdata1<=wb_data. Same rule for rt. This keeps held operands current.
- Register 0 is never bypassed; a write to $0 is ignored.
- load_use_stall = ex_valid && ex_ctrl.MemRead && ex_rt!=0 && id_valid && (ex_rt==id_rs || ex_rt==id_rt). Pure function of registered state and id_* inputs.
- Latency: 1 cycle from id_* to ex_*. No combinational path from id_* to ex_*.
- Reset released mid-stall: the first edge after release behaves per the stall/flush inputs of that edge.
- Simultaneous flush+stall: flush wins; a bubble is inserted.

Decomposition:
- Shared package pipe_pkg: control-bundle field index constants (CTRL_REGWRITE … CTRL_ALUOP_LSB), CW, REG_ZERO=5'd0, ALUOp encodings.
- One natural sub-module: operand_bypass (match compare plus mux, instantiated twice, once per operand). Use the same unit for the load and stall paths by selecting id_* or ex_* specifiers.

Test Plan:
- Reset: assert reset=0 mid-cycle -> all outputs 0 immediately; release, load id_rs=8, id_rdata1=0x1 -> next edge ex_rs=8, ex_rdata1=0x1, ex_valid=1.
- Load bypass: id_rs=9, id_rdata1=0x2, wb_regwrite=1, wb_reg=9, wb_data=0xABCD -> ex_rdata1=0xABCD. Repeat with wb_reg=0, id_rs=0, id_rdata1=0 -> ex_rdata1=0.
- Stall hold plus bypass: load ex_rt=18, rdata2=0x3; stall=1 for 2 cycles, WB writes reg 18=0x55 in cycle 2 -> ex_rdata2=0x55, all other fields unchanged.
- Flush priority: stall=1, flush=1 with valid contents -> ex_valid=0, ex_ctrl=0 next edge.
- Load-use: ex holds lw (MemRead=1) with ex_rt=20; id_rs=20 -> load_use_stall=1. id_rs=id_rt=21 -> 0. ex_rt=0 -> 0.
- Back-to-back stream: 8 consecutive instructions with no stall/flush -> each appears on ex_* exactly 1 cycle after presentation, no drops or duplicates.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline registers: control-bundle layout,
// register-zero specifier and ALU operation encodings.
package pipe_pkg;

    localparam int CW = 10;

    // Bit positions inside the decoded control bundle.
    localparam int CTRL_REGWRITE  = 9;
    localparam int CTRL_MEMREAD   = 8;
    localparam int CTRL_MEMWRITE  = 7;
    localparam int CTRL_MEMTOREG  = 6;
    localparam int CTRL_ALUSRC    = 5;
    localparam int CTRL_REGDST    = 4;
    localparam int CTRL_ALUOP_MSB = 3;
    localparam int CTRL_ALUOP_LSB = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALUOP_ADD = 4'd0,
        ALUOP_SUB = 4'd1,
        ALUOP_AND = 4'd2,
        ALUOP_OR  = 4'd3,
        ALUOP_SLT = 4'd4,
        ALUOP_XOR = 4'd5,
        ALUOP_NOR = 4'd6,
        ALUOP_SLL = 4'd7,
        ALUOP_SRL = 4'd8,
        ALUOP_LUI = 4'd9
    } aluop_e;

    function automatic logic ctrl_memread(input logic [CW-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Replaces an operand with same-cycle writeback data when the writeback
// targets the operand's source register (never register zero).
module operand_bypass
    import pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          en,
    input  logic [AW-1:0] src_reg,
    input  logic [DW-1:0] src_data,
    input  logic          wb_regwrite,
    input  logic [AW-1:0] wb_reg,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] byp_data
);

    logic hit;

    assign hit      = en && wb_regwrite && (wb_reg != AW'(REG_ZERO)) && (wb_reg == src_reg);
    assign byp_data = hit ? wb_data : src_data;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall, flush, writeback bypass of captured or
// held operands, and load-use hazard detection for the front end.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic [CW-1:0] id_ctrl,
    input  logic          stall,
    input  logic          flush,
    input  logic          wb_regwrite,
    input  logic [AW-1:0] wb_reg,
    input  logic [DW-1:0] wb_data,
    output logic          ex_valid,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic [AW-1:0] ex_rd,
    output logic [DW-1:0] ex_rdata1,
    output logic [DW-1:0] ex_rdata2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic [CW-1:0] ex_ctrl,
    output logic          load_use_stall
);

    import pipe_pkg::*;

    logic          ex_valid_q,  ex_valid_d;
    logic [AW-1:0] ex_rs_q,     ex_rs_d;
    logic [AW-1:0] ex_rt_q,     ex_rt_d;
    logic [AW-1:0] ex_rd_q,     ex_rd_d;
    logic [DW-1:0] ex_rdata1_q, ex_rdata1_d;
    logic [DW-1:0] ex_rdata2_q, ex_rdata2_d;
    logic [DW-1:0] ex_imm_q,    ex_imm_d;
    logic [DW-1:0] ex_pc4_q,    ex_pc4_d;
    logic [CW-1:0] ex_ctrl_q,   ex_ctrl_d;

    // One bypass unit per operand serves both paths: while stalled it looks
    // at the held specifiers/data, otherwise at the incoming decode values.
    logic          byp_en;
    logic [AW-1:0] byp_rs, byp_rt;
    logic [DW-1:0] byp_src1, byp_src2;
    logic [DW-1:0] byp_data1, byp_data2;

    assign byp_en   = stall ? ex_valid_q  : 1'b1;
    assign byp_rs   = stall ? ex_rs_q     : id_rs;
    assign byp_rt   = stall ? ex_rt_q     : id_rt;
    assign byp_src1 = stall ? ex_rdata1_q : id_rdata1;
    assign byp_src2 = stall ? ex_rdata2_q : id_rdata2;

    operand_bypass #(.DW(DW), .AW(AW)) u_byp_rs (
        .en          (byp_en),
        .src_reg     (byp_rs),
        .src_data    (byp_src1),
        .wb_regwrite (wb_regwrite),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .byp_data    (byp_data1)
    );

    operand_bypass #(.DW(DW), .AW(AW)) u_byp_rt (
        .en          (byp_en),
        .src_reg     (byp_rt),
        .src_data    (byp_src2),
        .wb_regwrite (wb_regwrite),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .byp_data    (byp_data2)
    );

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rs_d     = ex_rs_q;
        ex_rt_d     = ex_rt_q;
        ex_rd_d     = ex_rd_q;
        ex_rdata1_d = ex_rdata1_q;
        ex_rdata2_d = ex_rdata2_q;
        ex_imm_d    = ex_imm_q;
        ex_pc4_d    = ex_pc4_q;
        ex_ctrl_d   = ex_ctrl_q;
        if (flush) begin
            ex_valid_d  = 1'b0;
            ex_rs_d     = '0;
            ex_rt_d     = '0;
            ex_rd_d     = '0;
            ex_rdata1_d = '0;
            ex_rdata2_d = '0;
            ex_imm_d    = '0;
            ex_pc4_d    = '0;
            ex_ctrl_d   = '0;
        end else if (stall) begin
            ex_rdata1_d = byp_data1;
            ex_rdata2_d = byp_data2;
        end else begin
            ex_valid_d  = id_valid;
            ex_rs_d     = id_rs;
            ex_rt_d     = id_rt;
            ex_rd_d     = id_rd;
            ex_rdata1_d = byp_data1;
            ex_rdata2_d = byp_data2;
            ex_imm_d    = id_imm;
            ex_pc4_d    = id_pc4;
            ex_ctrl_d   = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q  <= 1'b0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            ex_rdata1_q <= '0;
            ex_rdata2_q <= '0;
            ex_imm_q    <= '0;
            ex_pc4_q    <= '0;
            ex_ctrl_q   <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_rd_q     <= ex_rd_d;
            ex_rdata1_q <= ex_rdata1_d;
            ex_rdata2_q <= ex_rdata2_d;
            ex_imm_q    <= ex_imm_d;
            ex_pc4_q    <= ex_pc4_d;
            ex_ctrl_q   <= ex_ctrl_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_rs     = ex_rs_q;
    assign ex_rt     = ex_rt_q;
    assign ex_rd     = ex_rd_q;
    assign ex_rdata1 = ex_rdata1_q;
    assign ex_rdata2 = ex_rdata2_q;
    assign ex_imm    = ex_imm_q;
    assign ex_pc4    = ex_pc4_q;
    assign ex_ctrl   = ex_ctrl_q;

    assign load_use_stall = ex_valid_q && ctrl_memread(ex_ctrl_q) && (ex_rt_q != AW'(REG_ZERO))
                            && id_valid && ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the EX-side record.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic [9:0]  id_ctrl;
    logic        stall, flush;
    logic        wb_regwrite;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic [9:0]  ex_ctrl;
    logic        load_use_stall;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_rdata1      (id_rdata1),
        .id_rdata2      (id_rdata2),
        .id_imm         (id_imm),
        .id_pc4         (id_pc4),
        .id_ctrl        (id_ctrl),
        .stall          (stall),
        .flush          (flush),
        .wb_regwrite    (wb_regwrite),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .ex_valid       (ex_valid),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_rd          (ex_rd),
        .ex_rdata1      (ex_rdata1),
        .ex_rdata2      (ex_rdata2),
        .ex_imm         (ex_imm),
        .ex_pc4         (ex_pc4),
        .ex_ctrl        (ex_ctrl),
        .load_use_stall (load_use_stall)
    );

    // Expected contents of the EX stage as an instruction record.
    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, rd;
        logic [31:0] r1, r2, imm, pc4;
        logic [9:0]  ctrl;
    } ex_rec_t;

    ex_rec_t m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic ex_rec_t empty_rec();
        ex_rec_t r;
        r.v = 0; r.rs = 0; r.rt = 0; r.rd = 0;
        r.r1 = 0; r.r2 = 0; r.imm = 0; r.pc4 = 0; r.ctrl = 0;
        return r;
    endfunction

    // True when the writeback in flight this cycle lands in register `r`.
    function automatic bit wb_writes(input logic [4:0] r);
        return wb_regwrite && wb_reg != 0 && wb_reg == r;
    endfunction

    function automatic ex_rec_t model_next(input ex_rec_t cur);
        ex_rec_t n = cur;
        if (flush) begin
            n = empty_rec();
        end else if (stall) begin
            if (cur.v && wb_writes(cur.rs)) n.r1 = wb_data;
            if (cur.v && wb_writes(cur.rt)) n.r2 = wb_data;
        end else begin
            n.v = id_valid; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
            n.imm = id_imm; n.pc4 = id_pc4;
            n.ctrl = id_valid ? id_ctrl : 10'd0;
            n.r1 = wb_writes(id_rs) ? wb_data : id_rdata1;
            n.r2 = wb_writes(id_rt) ? wb_data : id_rdata2;
        end
        return n;
    endfunction

    function automatic logic model_lus();
        // A load sitting in EX whose destination the decoding instruction reads.
        return m.v && m.ctrl[8] && m.rt != 0 && id_valid && (m.rt == id_rs || m.rt == id_rt);
    endfunction

    task automatic compare_all();
        chk("ex_valid",  ex_valid,  m.v);
        chk("ex_rs",     ex_rs,     m.rs);
        chk("ex_rt",     ex_rt,     m.rt);
        chk("ex_rd",     ex_rd,     m.rd);
        chk("ex_rdata1", ex_rdata1, m.r1);
        chk("ex_rdata2", ex_rdata2, m.r2);
        chk("ex_imm",    ex_imm,    m.imm);
        chk("ex_pc4",    ex_pc4,    m.pc4);
        chk("ex_ctrl",   ex_ctrl,   m.ctrl);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; id_pc4 = 0; id_ctrl = 0;
        stall = 0; flush = 0; wb_regwrite = 0; wb_reg = 0; wb_data = 0;
    endtask

    task automatic rand_id(input bit narrow);
        id_valid  = ($urandom_range(0, 7) != 0);
        id_rs     = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        id_rt     = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        id_rd     = 5'($urandom);
        id_rdata1 = $urandom;
        id_rdata2 = $urandom;
        id_imm    = $urandom;
        id_pc4    = $urandom;
        id_ctrl   = 10'($urandom);
    endtask

    // Inputs are already driven; check the combinational output, take one
    // edge, advance the model and compare all registered outputs.
    task automatic cycle();
        #1;
        chk("load_use_stall", load_use_stall, model_lus());
        @(posedge clk);
        m = model_next(m);
        #1;
        compare_all();
    endtask

    initial begin
        logic [31:0] pc_q[$];
        logic [31:0] pc_exp;

        idle_inputs();
        reset = 0;
        m = empty_rec();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_lus", load_use_stall, 1'b0);
        #2 reset = 1;

        // First load after reset release.
        id_valid = 1; id_rs = 8; id_rdata1 = 32'h1; id_ctrl = 10'h2A5;
        cycle();
        chk("rel_ex_rs", ex_rs, 5'd8);
        chk("rel_ex_rdata1", ex_rdata1, 32'h1);
        chk("rel_ex_valid", ex_valid, 1'b1);

        // Asynchronous reset mid-cycle clears everything without a clock edge.
        reset = 0;
        #1;
        m = empty_rec();
        compare_all();
        chk("async_lus", load_use_stall, 1'b0);
        reset = 1;
        #1;

        // Load-path bypass, then a write to $0 that must not bypass.
        idle_inputs();
        id_valid = 1; id_rs = 9; id_rdata1 = 32'h2;
        wb_regwrite = 1; wb_reg = 9; wb_data = 32'hABCD;
        cycle();
        chk("load_byp", ex_rdata1, 32'hABCD);
        id_rs = 0; id_rdata1 = 0; wb_reg = 0;
        cycle();
        chk("load_byp_r0", ex_rdata1, 32'h0);

        // Stall holds contents while the held rt operand picks up a writeback.
        idle_inputs();
        id_valid = 1; id_rs = 3; id_rt = 18; id_rd = 7; id_rdata1 = 32'h11; id_rdata2 = 32'h3;
        id_imm = 32'h44; id_pc4 = 32'h100; id_ctrl = 10'h021;
        cycle();
        stall = 1;
        rand_id(0);
        cycle();
        wb_regwrite = 1; wb_reg = 18; wb_data = 32'h55;
        cycle();
        chk("stall_byp_rdata2", ex_rdata2, 32'h55);
        chk("stall_rt", ex_rt, 5'd18);
        chk("stall_rdata1", ex_rdata1, 32'h11);
        chk("stall_pc4", ex_pc4, 32'h100);

        // Flush beats stall.
        idle_inputs();
        id_valid = 1; id_rt = 4; id_ctrl = 10'h3FF;
        cycle();
        stall = 1; flush = 1;
        cycle();
        chk("flush_valid", ex_valid, 1'b0);
        chk("flush_ctrl", ex_ctrl, 10'd0);

        // Load-use detection against a lw sitting in EX.
        idle_inputs();
        id_valid = 1; id_rt = 20; id_ctrl = 10'h300;
        cycle();
        id_rs = 20; id_rt = 5;
        #1 chk("lus_hit", load_use_stall, 1'b1);
        id_rs = 21; id_rt = 21;
        #1 chk("lus_miss", load_use_stall, 1'b0);
        id_rs = 0; id_rt = 0;
        cycle();
        #1 chk("lus_rt0", load_use_stall, 1'b0);

        // Back-to-back stream: every instruction appears exactly one cycle later.
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            rand_id(0);
            id_valid = 1;
            id_pc4 = 32'h400 + 32'(4 * i);
            pc_q.push_back(id_pc4);
            cycle();
            pc_exp = pc_q.pop_front();
            chk("stream_pc4", ex_pc4, pc_exp);
        end

        // Randomized traffic with narrow register ranges to provoke bypass hits.
        for (int i = 0; i < 400; i++) begin
            rand_id($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            wb_regwrite = $urandom_range(0, 1);
            wb_reg      = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wb_data     = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
